l1_miss_tracker: RTL
====================

# l1_miss_tracker

- Next-generation L1 miss tracking queue, sitting between the L1 data cache tag/miss-detect stage and the L2 request interface.
- Decouples miss-entry count from thread count: entries are allocated from a free pool.
- Merges non-synchronized misses to the same cache line, round-robin arbitrates unsent entries to L2, and wakes all waiting threads when L2 responds.
- Also reports occupancy and full status, and optionally flags L2 responses that never arrive.

## Interface
- NUM_ENTRIES, 8, number of tracked misses (≥2, power of two)
- NUM_THREADS, 4, hardware threads sharing the queue
- ADDR_WIDTH, 26, cache-line address width
- TIMEOUT_CYCLES, 4096, watchdog limit; only used with L1_MISS_TIMEOUT_EN
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cache_miss  in  1  enqueue request this cycle
- cache_miss_addr  in  ADDR_WIDTH  line address of miss
- cache_miss_thread_idx  in  $clog2(NUM_THREADS)  requesting thread
- cache_miss_synchronized  in  1  load-linked/synchronized miss; never merged
- full  out  1  no free entry; a new (non-merging) miss must not be issued
- pending_count  out  $clog2(NUM_ENTRIES+1)  valid entries
- dequeue_ready  out  1  an unsent valid entry exists
- dequeue_ack  in  1  L2 accepted the presented request
- dequeue_addr  out  ADDR_WIDTH  address of granted entry
- dequeue_idx  out  $clog2(NUM_ENTRIES)  granted entry index, echoed by L2
- dequeue_synchronized  out  1  synchronized flag of granted entry
- l2_response_valid  in  1  L2 fill for an entry
- l2_response_idx  in  $clog2(NUM_ENTRIES)  entry being filled
- wake_bitmap  out  NUM_THREADS  threads to wake; zero when no response
- timeout_error  out  1  one-cycle pulse; watchdog expired (feature only)
- timeout_idx  out  $clog2(NUM_ENTRIES)  entry that expired (feature only)

## Operation
- Entry state: valid, sent, synchronized, address, waiting bitmap.
- Collision: entry is valid, addresses match, neither side is synchronized, and the entry is not retiring this cycle.
- On collision with cache_miss, OR the thread one-hot into that entry's waiting bitmap. No allocation. Legal even when full.
- Otherwise allocate the lowest-index free entry: valid=1, sent=0, waiting=thread one-hot, synchronized flag and address captured.
- Free mask is taken from the current-cycle state. An entry retiring this cycle is not reusable until the next cycle.
- Arbitration: round-robin over valid && !sent entries. On dequeue_ack, set sent on the granted entry and advance priority to the index after it.
- Response: wake_bitmap = waiting bitmap of l2_response_idx (combinational); the entry's valid clears at the edge.
- pending_count = popcount(valid), registered.
- Assertions (simulation):
  - allocation while full;
  - response to an invalid or unsent entry;
  - ack while !dequeue_ready;
  - thread already waiting in any entry issuing a miss.

## Timing
- Reset values: all entries invalid, priority at 0, full=0, pending_count=0, dequeue_ready=0, wake_bitmap=0, timeout_error=0, timeout_idx=0.
- Reset is asynchronous; reset asserted mid-operation discards all entries with no wake.
- Allocated entry raises dequeue_ready at the earliest in the cycle after enqueue.
- Dequeue outputs are combinational from registered state. The ack takes effect at the same edge.
- Ack and response on the same entry in one cycle is illegal (entry must already be sent).
- Simultaneous enqueue, ack and response on three different entries are all honoured in one cycle.
- full, pending_count and dequeue_ready reflect post-edge state.

## Configuration
- L1_MISS_TIMEOUT_EN defined:
  - per-entry counter resets on the ack edge and increments each cycle while sent and valid;
  - reaching TIMEOUT_CYCLES pulses timeout_error for one cycle with timeout_idx;
  - the counter then saturates; the entry remains tracked;
  - the lowest index wins if several entries expire together.
- L1_MISS_TIMEOUT_EN undefined: no counters; timeout_error and timeout_idx tied to 0.

## Structure
- The shared defines package holds:
  - cache-line address type;
  - thread_idx_t and thread_bitmap_t;
  - l1_miss_entry_idx_t, sized from a shared L1_MISS_ENTRIES constant that the top level passes as NUM_ENTRIES.
- Reuse the existing round-robin `arbiter` (update_lru driven by dequeue_ack) and `oh_to_idx`/`idx_to_oh`.
- Natural sub-module: `l1_miss_entry`, one per entry (state plus optional watchdog), generated NUM_ENTRIES times.

## Test plan
- Merge: thread 0 misses 0x100, then thread 2 misses 0x100 → one entry, pending_count=1; ack then response idx 0 → wake_bitmap=4'b0101.
- Synchronized: thread 1 sync miss 0x200, then thread 3 normal miss 0x200 → two entries; responses wake 4'b0010 and 4'b1000 separately.
- Full: 8 distinct misses → full=1. A miss to an existing non-sync address still merges. Response idx 5 → full=0 the next cycle, and the next miss allocates idx 5.
- Arbitration: entries 0, 1, 2 unsent with ack held high → dequeue_idx sequence 0, 1, 2, then dequeue_ready=0.
- Retire race: response to idx 3 (addr 0x40) in the same cycle as a new miss to 0x40 → no merge; a new entry is allocated at the lowest free index, not 3; wake excludes the new thread.
- Timeout (macro on, TIMEOUT_CYCLES=16): ack idx 2 and withhold the response → timeout_error pulses once, 16 cycles after the ack, with timeout_idx=2.

Source files
------------

// File: rtl/l1_miss_tracker_pkg.sv
// l1_miss_tracker_pkg: shared cache-line, thread and miss-entry types
package l1_miss_tracker_pkg;
    localparam int L1_MISS_ENTRIES = 8;
    localparam int L1_THREADS = 4;
    localparam int CACHE_LINE_WIDTH = 26;
    typedef logic [CACHE_LINE_WIDTH-1:0] cache_line_addr_t;
    typedef logic [$clog2(L1_THREADS)-1:0] thread_idx_t;
    typedef logic [L1_THREADS-1:0] thread_bitmap_t;
    typedef logic [$clog2(L1_MISS_ENTRIES)-1:0] l1_miss_entry_idx_t;
endpackage

// File: rtl/arbiter.sv
// arbiter: round-robin grant; priority moves past the winner on update_lru
module arbiter #(
    parameter int NUM_REQUESTERS = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQUESTERS-1:0] request,
    input  logic                      update_lru,
    output logic [NUM_REQUESTERS-1:0] grant_oh
);
    localparam int W = $clog2(NUM_REQUESTERS);
    logic [W-1:0] prio, idx, grant_idx;
    always_comb begin
        grant_oh = '0;
        grant_idx = prio;
        idx = '0;
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            idx = prio + W'(k);
            if (request[idx] && grant_oh == '0) begin
                grant_oh[idx] = 1'b1;
                grant_idx = idx;
            end
        end
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            prio <= '0;
        else if (update_lru && |grant_oh)
            prio <= grant_idx + 1'b1;
endmodule

// File: rtl/l1_miss_tracker_entry.sv
// l1_miss_entry: one tracked miss line plus optional response watchdog (L1_MISS_TIMEOUT_EN)
module l1_miss_entry #(
    parameter int ADDR_WIDTH = 26,
    parameter int NUM_THREADS = 4
`ifdef L1_MISS_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   alloc,
    input  logic                   merge,
    input  logic                   ack,
    input  logic                   retire,
    input  logic                   alloc_sync,
    input  logic [ADDR_WIDTH-1:0]  alloc_addr,
    input  logic [NUM_THREADS-1:0] thread_oh,
    output logic                   valid,
    output logic                   sent,
    output logic                   sync,
    output logic [ADDR_WIDTH-1:0]  addr,
    output logic [NUM_THREADS-1:0] waiting
`ifdef L1_MISS_TIMEOUT_EN
    , output logic                 timeout_hit
`endif
);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            valid <= 1'b0;
            sent <= 1'b0;
            sync <= 1'b0;
            addr <= '0;
            waiting <= '0;
        end else if (alloc) begin
            valid <= 1'b1;
            sent <= 1'b0;
            sync <= alloc_sync;
            addr <= alloc_addr;
            waiting <= thread_oh;
        end else begin
            if (retire) valid <= 1'b0;
            if (merge) waiting <= waiting | thread_oh;
            if (ack) sent <= 1'b1;
        end
`ifdef L1_MISS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            cnt <= '0;
        else if (ack)
            cnt <= '0;
        else if (valid && sent && cnt != CW'(TIMEOUT_CYCLES))
            cnt <= cnt + 1'b1;
    // Fires on the cycle before saturation so the registered pulse lands exactly at the limit
    assign timeout_hit = valid && sent && !retire && cnt == CW'(TIMEOUT_CYCLES - 1);
`endif
endmodule

// File: rtl/oh_to_idx.sv
// oh_to_idx / idx_to_oh: one-hot and binary index conversion
module oh_to_idx #(
    parameter int NUM_SIGNALS = 4
) (
    input  logic [NUM_SIGNALS-1:0]         one_hot,
    output logic [$clog2(NUM_SIGNALS)-1:0] index
);
    always_comb begin
        index = '0;
        for (int k = 0; k < NUM_SIGNALS; k++)
            index = index | (one_hot[k] ? ($clog2(NUM_SIGNALS))'(k) : '0);
    end
endmodule

module idx_to_oh #(
    parameter int NUM_SIGNALS = 4
) (
    input  logic [$clog2(NUM_SIGNALS)-1:0] index,
    output logic [NUM_SIGNALS-1:0]         one_hot
);
    assign one_hot = NUM_SIGNALS'(1) << index;
endmodule

// File: rtl/l1_miss_tracker.sv
// l1_miss_tracker: L1 miss queue with line merging, round-robin L2 issue and wake-up;
// L1_MISS_TIMEOUT_EN adds a per-entry response watchdog.
module l1_miss_tracker
    import l1_miss_tracker_pkg::*;
#(
    parameter int NUM_ENTRIES = L1_MISS_ENTRIES,
    parameter int NUM_THREADS = L1_THREADS,
    parameter int ADDR_WIDTH = CACHE_LINE_WIDTH,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             cache_miss,
    input  logic [ADDR_WIDTH-1:0]            cache_miss_addr,
    input  logic [$clog2(NUM_THREADS)-1:0]   cache_miss_thread_idx,
    input  logic                             cache_miss_synchronized,
    output logic                             full,
    output logic [$clog2(NUM_ENTRIES+1)-1:0] pending_count,
    output logic                             dequeue_ready,
    input  logic                             dequeue_ack,
    output logic [ADDR_WIDTH-1:0]            dequeue_addr,
    output logic [$clog2(NUM_ENTRIES)-1:0]   dequeue_idx,
    output logic                             dequeue_synchronized,
    input  logic                             l2_response_valid,
    input  logic [$clog2(NUM_ENTRIES)-1:0]   l2_response_idx,
    output logic [NUM_THREADS-1:0]           wake_bitmap,
    output logic                             timeout_error,
    output logic [$clog2(NUM_ENTRIES)-1:0]   timeout_idx
);
    localparam int PW = $clog2(NUM_ENTRIES + 1);
    logic [NUM_ENTRIES-1:0] valid, sent, sync, collide, free, alloc_oh, grant_oh, ack_oh, resp_oh, retire_oh;
    logic [ADDR_WIDTH-1:0] addr [NUM_ENTRIES];
    logic [NUM_THREADS-1:0] waiting [NUM_ENTRIES];
    logic [NUM_THREADS-1:0] thread_oh, waiting_any;
`ifdef L1_MISS_TIMEOUT_EN
    logic [NUM_ENTRIES-1:0] timeout_hit;
    logic [$clog2(NUM_ENTRIES)-1:0] hit_idx;
`endif

    idx_to_oh #(.NUM_SIGNALS(NUM_THREADS)) u_thread_oh (.index(cache_miss_thread_idx), .one_hot(thread_oh));
    idx_to_oh #(.NUM_SIGNALS(NUM_ENTRIES)) u_resp_oh (.index(l2_response_idx), .one_hot(resp_oh));
    arbiter #(.NUM_REQUESTERS(NUM_ENTRIES)) u_arbiter (
        .clk(clk), .reset_n(reset_n), .request(valid & ~sent), .update_lru(dequeue_ack), .grant_oh(grant_oh));
    oh_to_idx #(.NUM_SIGNALS(NUM_ENTRIES)) u_grant_idx (.one_hot(grant_oh), .index(dequeue_idx));

    assign retire_oh = l2_response_valid ? resp_oh : '0;
    assign ack_oh = dequeue_ack ? grant_oh : '0;
    // Free pool is current state only: a retiring entry is still valid here and not reusable yet
    assign free = ~valid;
    assign alloc_oh = (cache_miss && !(|collide)) ? free & (~free + 1'b1) : '0;

    for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_entry
        assign collide[i] = valid[i] && addr[i] == cache_miss_addr && !sync[i]
            && !cache_miss_synchronized && !retire_oh[i];
        l1_miss_entry #(
            .ADDR_WIDTH(ADDR_WIDTH), .NUM_THREADS(NUM_THREADS)
`ifdef L1_MISS_TIMEOUT_EN
            , .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
`endif
        ) u_entry (
            .clk(clk), .reset_n(reset_n), .alloc(alloc_oh[i]), .merge(cache_miss && collide[i]),
            .ack(ack_oh[i]), .retire(retire_oh[i]), .alloc_sync(cache_miss_synchronized),
            .alloc_addr(cache_miss_addr), .thread_oh(thread_oh), .valid(valid[i]), .sent(sent[i]),
            .sync(sync[i]), .addr(addr[i]), .waiting(waiting[i])
`ifdef L1_MISS_TIMEOUT_EN
            , .timeout_hit(timeout_hit[i])
`endif
        );
    end

    assign full = &valid;
    assign dequeue_ready = |(valid & ~sent);
    assign dequeue_addr = addr[dequeue_idx];
    assign dequeue_synchronized = sync[dequeue_idx];
    assign wake_bitmap = l2_response_valid ? waiting[l2_response_idx] : '0;

    always_comb begin
        pending_count = '0;
        waiting_any = '0;
        for (int k = 0; k < NUM_ENTRIES; k++) begin
            pending_count = pending_count + PW'(valid[k]);
            waiting_any = waiting_any | ((valid[k] && !retire_oh[k]) ? waiting[k] : '0);
        end
    end

`ifdef L1_MISS_TIMEOUT_EN
    oh_to_idx #(.NUM_SIGNALS(NUM_ENTRIES)) u_hit_idx (.one_hot(timeout_hit & (~timeout_hit + 1'b1)), .index(hit_idx));
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            timeout_error <= 1'b0;
            timeout_idx <= '0;
        end else begin
            timeout_error <= |timeout_hit;
            if (|timeout_hit) timeout_idx <= hit_idx;
        end
`else
    assign timeout_error = 1'b0;
    assign timeout_idx = '0;
`endif

    assert property (@(posedge clk) TIMEOUT_CYCLES >= 2);
    assert property (@(posedge clk) disable iff (!reset_n) !(cache_miss && !(|collide) && full));
    assert property (@(posedge clk) disable iff (!reset_n)
        l2_response_valid |-> valid[l2_response_idx] && sent[l2_response_idx]);
    assert property (@(posedge clk) disable iff (!reset_n) dequeue_ack |-> dequeue_ready);
    assert property (@(posedge clk) disable iff (!reset_n) cache_miss |-> !(|(waiting_any & thread_oh)));
endmodule
